display_source_arbiter: RTL and testbench
=========================================

Name: display_source_arbiter

Overview:
- Owns the shared LED bank and OLED pixel stream. Chooses which source drives them: student A, B, C or D (each unlocked by its switch password), or the init screen.
- A source change takes effect only after the password has been stable for a qualification period, and only on a frame boundary. One or more black frames are inserted between sources, so the panel never shows a torn mixed frame.
- Sits in Top_Student between the student modules and Oled_Display. It replaces the ad-hoc priority mux there.

Parameters:
- STABLE_CYCLES, 1_000_000: clock_100mhz cycles a new request must hold before it is accepted (10 ms). Must be ≥1.
- BLANK_FRAMES, 2: number of black frames inserted at each switch. 0 is legal and means no blanking.

Ports:
- clock_100mhz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- password_match  in  4  bit0=A, bit1=B, bit2=C, bit3=D; level, synchronous to clock_100mhz
- frame_begin  in  1  Oled_Display frame pulse, 6.25 MHz domain
- sw  in  16  switches; LED content for the init screen
- led_A, led_B, led_C, led_D  in  16 each  student LED words
- oled_data_A, oled_data_B, oled_data_C, oled_data_D  in  16 each  student pixel data
- oled_data_init  in  16  init-screen pixel data
- led  out  16  registered LED output
- oled_data  out  16  registered pixel output
- active_src  out  3  committed source: 0–3 = A–D, 4 = INIT
- src_enable  out  4  one-hot enable for the committed student; 0 when INIT or switching
- switching  out  1  high in QUALIFY, WAIT_FRAME and BLANK

Behaviour:
- Request encoding:
  - req = priority encode of password_match, with A highest, then B, C, D.
  - req = 4 (INIT) when no bit is set.
- Frame tick:
  - frame_begin passes through a 2-FF synchronizer and a rising-edge detector, giving a one-cycle frame_tick.
  - Latency from the frame_begin rising edge is 3 clock_100mhz cycles.
- Reset (asynchronous assert, synchronous release):
  - state=STEADY, cur=4, cand=4.
  - cnt=0, fcnt=0.
  - led=0, oled_data=0, src_enable=0, active_src=4, switching=0.
- STEADY:
  - If req==cur, stay.
  - Otherwise cand←req, cnt←0, go to QUALIFY.
- QUALIFY:
  - If req==cur, abort to STEADY.
  - If req differs from both cand and cur, cand←req and cnt←0.
  - Else cnt increments; at cnt==STABLE_CYCLES-1, go to WAIT_FRAME.
- WAIT_FRAME:
  - If req==cur, go to STEADY.
  - If req≠cand and req≠cur, go to QUALIFY with cand←req and cnt←0.
  - On frame_tick: cur←cand, fcnt←0. Go to BLANK, or to STEADY directly if BLANK_FRAMES==0.
  - If a req change and a frame_tick occur in the same cycle, the req check wins.
- BLANK:
  - Committed; req changes are ignored.
  - Each frame_tick increments fcnt; when fcnt reaches BLANK_FRAMES, go to STEADY.
  - Any new request is handled from STEADY afterwards.
- Output mux (registered, one cycle after state and inputs):
  - STEADY, or QUALIFY/WAIT_FRAME (old source still shown):
    - cur=0–3: led=led_X, oled_data=oled_data_X.
    - cur=4: led=sw, oled_data=oled_data_init.
  - BLANK: led=0, oled_data=16'h0000.
- Status outputs:
  - active_src = cur, registered.
  - src_enable = one-hot(cur) in STEADY when cur<4, else 0.
  - switching = (state≠STEADY).
- Widths:
  - cnt is $clog2(STABLE_CYCLES+1) bits.
  - fcnt is $clog2(BLANK_FRAMES+1) bits, minimum 1.
  - No wrap: cnt stops at its terminal value.
- Simultaneous password bits resolve by priority. A–D passwords are mutually exclusive by construction, but the arbiter still must not glitch if two bits are set.
- Reset mid-switch returns to INIT immediately. led and oled_data go to 0 asynchronously.

Decomposition:
- Package display_arb_pkg:
  - source codes SRC_A..SRC_D = 0..3, SRC_INIT = 4
  - state enum {STEADY, QUALIFY, WAIT_FRAME, BLANK}
  - BLACK = 16'h0000
- One sub-module: frame_tick_sync, holding the synchronizer and edge detector.

Test Plan (STABLE_CYCLES=8, BLANK_FRAMES=2, frame_begin pulse every 200 cycles):
- After reset, no password, sw=16'hA5A5 → led=16'hA5A5 and oled_data=oled_data_init from cycle 2; active_src=4; src_enable=0.
- Assert password_match=4'b1000 and hold → after 8 cycles waits for frame_tick. Then 2 black frames with oled_data=0 and led=0. Then active_src=3, src_enable=4'b1000, led=led_D, switching=0.
- Pulse password_match=4'b0010 for 5 cycles, then back to 0 → returns to STEADY; active_src stays 4; oled_data never goes black.
- From D, change to B during WAIT_FRAME → cand=1, cnt restarts; the first frame_tick ≥8 cycles later commits B; the panel never shows D→black→D.
- password_match=4'b1010 → selects B (priority); after blanking, active_src=1.
- Assert reset_n=0 mid-BLANK → outputs go to 0 that cycle. After release: active_src=4, state=STEADY, led=sw.
- BLANK_FRAMES=0 build, request A → active_src=0 on the first frame_tick + 1 cycle; no black frame.

Source files
------------

// File: rtl/display_arb_pkg.sv
// Shared types for the display source arbiter: source codes, FSM states and
// the request priority encoder.
`timescale 1ns/1ps
package display_arb_pkg;

  typedef logic [2:0] src_t;

  localparam src_t SRC_A    = 3'd0;
  localparam src_t SRC_B    = 3'd1;
  localparam src_t SRC_C    = 3'd2;
  localparam src_t SRC_D    = 3'd3;
  localparam src_t SRC_INIT = 3'd4;

  typedef enum logic [1:0] {STEADY, QUALIFY, WAIT_FRAME, BLANK} state_t;

  localparam logic [15:0] BLACK = 16'h0000;

  // A wins over B, B over C, C over D; no bit set falls back to the init screen.
  function automatic src_t encode_req(input logic [3:0] pm);
    src_t s;
    if (pm[0])      s = SRC_A;
    else if (pm[1]) s = SRC_B;
    else if (pm[2]) s = SRC_C;
    else if (pm[3]) s = SRC_D;
    else            s = SRC_INIT;
    return s;
  endfunction

  function automatic logic [3:0] src_onehot(input src_t s);
    logic [3:0] oh;
    oh = '0;
    if (s < SRC_INIT) oh[s[1:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the OLED frame pulse into the 100 MHz domain and turns its rising
// edge into a single-cycle tick (3 cycles after the edge is first sampled).
`timescale 1ns/1ps
module frame_tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_begin_i,
  output logic frame_tick_o
);

  logic [2:0] sync_q;
  logic       tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_begin_i};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/display_source_arbiter.sv
// Selects which student (or the init screen) drives the LED bank and OLED
// stream; switches only after a stable request, on a frame edge, with blanking.
`timescale 1ns/1ps
module display_source_arbiter
  import display_arb_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int BLANK_FRAMES  = 2
) (
  input  logic        clock_100mhz,
  input  logic        reset_n,
  input  logic [3:0]  password_match,
  input  logic        frame_begin,
  input  logic [15:0] sw,
  input  logic [15:0] led_A,
  input  logic [15:0] led_B,
  input  logic [15:0] led_C,
  input  logic [15:0] led_D,
  input  logic [15:0] oled_data_A,
  input  logic [15:0] oled_data_B,
  input  logic [15:0] oled_data_C,
  input  logic [15:0] oled_data_D,
  input  logic [15:0] oled_data_init,
  output logic [15:0] led,
  output logic [15:0] oled_data,
  output logic [2:0]  active_src,
  output logic [3:0]  src_enable,
  output logic        switching
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int FCNT_W = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [FCNT_W-1:0] FCNT_DONE = FCNT_W'(BLANK_FRAMES);

  logic              frame_tick;
  src_t              req;
  state_t            state_q, state_d;
  src_t              cur_q, cur_d, cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc;
  logic [15:0]       led_q, led_d, oled_q, oled_d;
  logic [3:0]        src_enable_q, src_enable_d;
  logic              switching_q, switching_d;

  frame_tick_sync u_frame_tick_sync (
    .clk_i        (clock_100mhz),
    .rst_ni       (reset_n),
    .frame_begin_i(frame_begin),
    .frame_tick_o (frame_tick)
  );

  assign req      = encode_req(password_match);
  assign fcnt_inc = fcnt_q + FCNT_W'(1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      STEADY: begin
        if (req != cur_q) begin
          cand_d  = req;
          cnt_d   = '0;
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (req == cur_q) begin
          state_d = STEADY;
        end else if (req != cand_q) begin
          cand_d = req;
          cnt_d  = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // Request changes take priority over a coincident frame tick.
        if (req == cur_q) begin
          state_d = STEADY;
        end else if (req != cand_q) begin
          cand_d  = req;
          cnt_d   = '0;
          state_d = QUALIFY;
        end else if (frame_tick) begin
          cur_d   = cand_q;
          fcnt_d  = '0;
          state_d = (BLANK_FRAMES == 0) ? STEADY : BLANK;
        end
      end
      BLANK: begin
        if (frame_tick) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc == FCNT_DONE) state_d = STEADY;
        end
      end
      default: state_d = STEADY;
    endcase
  end

  // Old source keeps showing until commit; only BLANK forces black.
  always_comb begin
    led_d  = sw;
    oled_d = oled_data_init;
    case (cur_q)
      SRC_A:   begin led_d = led_A; oled_d = oled_data_A; end
      SRC_B:   begin led_d = led_B; oled_d = oled_data_B; end
      SRC_C:   begin led_d = led_C; oled_d = oled_data_C; end
      SRC_D:   begin led_d = led_D; oled_d = oled_data_D; end
      default: begin led_d = sw;    oled_d = oled_data_init; end
    endcase
    if (state_q == BLANK) begin
      led_d  = BLACK;
      oled_d = BLACK;
    end
    switching_d  = (state_d != STEADY);
    src_enable_d = (state_d == STEADY) ? src_onehot(cur_d) : 4'b0000;
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= STEADY;
      cur_q        <= SRC_INIT;
      cand_q       <= SRC_INIT;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      led_q        <= '0;
      oled_q       <= '0;
      src_enable_q <= '0;
      switching_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      led_q        <= led_d;
      oled_q       <= oled_d;
      src_enable_q <= src_enable_d;
      switching_q  <= switching_d;
    end
  end

  assign led        = led_q;
  assign oled_data  = oled_q;
  assign active_src = cur_q;
  assign src_enable = src_enable_q;
  assign switching  = switching_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench: two arbiters (2 and 0 blanking frames) sharing stimulus,
// frame pulse every 200 cycles driven on the falling clock edge.
`timescale 1ns/1ps
module tb_display_source_arbiter;

  localparam logic [15:0] SWV = 16'hA5A5;
  localparam logic [15:0] LA = 16'h1111, LB = 16'h2222, LC = 16'h3333, LD = 16'h4444;
  localparam logic [15:0] OA = 16'hA001, OB = 16'hB002, OC = 16'hC003, OD = 16'hD004;
  localparam logic [15:0] OI = 16'h1234;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pm = 4'b0000;
  logic        frame_begin = 1'b0;
  logic [15:0] sw = SWV;
  logic [15:0] led_A = LA, led_B = LB, led_C = LC, led_D = LD;
  logic [15:0] oled_A = OA, oled_B = OB, oled_C = OC, oled_D = OD, oled_I = OI;

  logic [15:0] led, oled, led0, oled0;
  logic [2:0]  act, act0;
  logic [3:0]  sen, sen0;
  logic        swi, swi0;

  int n_chk = 0;
  int n_fail = 0;
  int fphase = 0;

  display_source_arbiter #(.STABLE_CYCLES(8), .BLANK_FRAMES(2)) dut (
    .clock_100mhz(clk), .reset_n(rst_n), .password_match(pm), .frame_begin(frame_begin),
    .sw(sw), .led_A(led_A), .led_B(led_B), .led_C(led_C), .led_D(led_D),
    .oled_data_A(oled_A), .oled_data_B(oled_B), .oled_data_C(oled_C), .oled_data_D(oled_D),
    .oled_data_init(oled_I), .led(led), .oled_data(oled), .active_src(act),
    .src_enable(sen), .switching(swi)
  );

  display_source_arbiter #(.STABLE_CYCLES(8), .BLANK_FRAMES(0)) dut0 (
    .clock_100mhz(clk), .reset_n(rst_n), .password_match(pm), .frame_begin(frame_begin),
    .sw(sw), .led_A(led_A), .led_B(led_B), .led_C(led_C), .led_D(led_D),
    .oled_data_A(oled_A), .oled_data_B(oled_B), .oled_data_C(oled_C), .oled_data_D(oled_D),
    .oled_data_init(oled_I), .led(led0), .oled_data(oled0), .active_src(act0),
    .src_enable(sen0), .switching(swi0)
  );

  always #5 clk = ~clk;

  // Frame pulse: high for 16 cycles out of 200, rising when fphase becomes 0.
  initial begin
    forever begin
      @(negedge clk);
      fphase = (fphase == 199) ? 0 : fphase + 1;
      frame_begin = (fphase < 16);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while (fphase != ph && k < 400) begin
      cyc(1);
      k++;
    end
    n_chk++; if (fphase != ph) begin n_fail++; $display("FAIL wait_phase: got %0d exp %0d", fphase, ph); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pm = 4'b0000;
    cyc(3);
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL rst_led: got %h exp %h", led, 16'h0000); end
    n_chk++; if (oled !== 16'h0000) begin n_fail++; $display("FAIL rst_oled: got %h exp %h", oled, 16'h0000); end
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL rst_act: got %0d exp %0d", act, 4); end
    n_chk++; if (sen !== 4'b0000) begin n_fail++; $display("FAIL rst_sen: got %b exp %b", sen, 4'b0000); end
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL rst_swi: got %b exp %b", swi, 1'b0); end
    rst_n = 1'b1;
    cyc(2);
    n_chk++; if (led !== SWV) begin n_fail++; $display("FAIL init_led: got %h exp %h", led, SWV); end
    n_chk++; if (oled !== OI) begin n_fail++; $display("FAIL init_oled: got %h exp %h", oled, OI); end
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL init_act: got %0d exp %0d", act, 4); end
    n_chk++; if (sen !== 4'b0000) begin n_fail++; $display("FAIL init_sen: got %b exp %b", sen, 4'b0000); end
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL init_swi: got %b exp %b", swi, 1'b0); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL async_led: got %h exp %h", led, 16'h0000); end
    n_chk++; if (oled !== 16'h0000) begin n_fail++; $display("FAIL async_oled: got %h exp %h", oled, 16'h0000); end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    $display("test_reset done");
  endtask

  task automatic test_switch_to_d;
    wait_phase(193);
    pm = 4'b1000;
    cyc(1);
    n_chk++; if (swi !== 1'b1) begin n_fail++; $display("FAIL d_qual_swi: got %b exp %b", swi, 1'b1); end
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL d_qual_act: got %0d exp %0d", act, 4); end
    cyc(8);
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL d_wait_act: got %0d exp %0d", act, 4); end
    n_chk++; if (led !== SWV) begin n_fail++; $display("FAIL d_wait_led: got %h exp %h", led, SWV); end
    cyc(1);
    n_chk++; if (act !== 3'd3) begin n_fail++; $display("FAIL d_commit_act: got %0d exp %0d", act, 3); end
    n_chk++; if (sen !== 4'b0000) begin n_fail++; $display("FAIL d_commit_sen: got %b exp %b", sen, 4'b0000); end
    n_chk++; if (led !== SWV) begin n_fail++; $display("FAIL d_commit_led: got %h exp %h", led, SWV); end
    cyc(1);
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL d_blank_led: got %h exp %h", led, 16'h0000); end
    n_chk++; if (oled !== 16'h0000) begin n_fail++; $display("FAIL d_blank_oled: got %h exp %h", oled, 16'h0000); end
    cyc(398);
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL d_blank_end_led: got %h exp %h", led, 16'h0000); end
    n_chk++; if (swi !== 1'b1) begin n_fail++; $display("FAIL d_blank_end_swi: got %b exp %b", swi, 1'b1); end
    cyc(1);
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL d_steady_swi: got %b exp %b", swi, 1'b0); end
    n_chk++; if (sen !== 4'b1000) begin n_fail++; $display("FAIL d_steady_sen: got %b exp %b", sen, 4'b1000); end
    n_chk++; if (act !== 3'd3) begin n_fail++; $display("FAIL d_steady_act: got %0d exp %0d", act, 3); end
    cyc(1);
    n_chk++; if (led !== LD) begin n_fail++; $display("FAIL d_steady_led: got %h exp %h", led, LD); end
    n_chk++; if (oled !== OD) begin n_fail++; $display("FAIL d_steady_oled: got %h exp %h", oled, OD); end
    $display("test_switch_to_d done");
  endtask

  task automatic test_glitch_abort;
    int bad;
    bad = 0;
    pm = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      if (i == 1) begin
        n_chk++; if (swi !== 1'b1) begin n_fail++; $display("FAIL glitch_swi_up: got %b exp %b", swi, 1'b1); end
      end
      if (led !== LD || act !== 3'd3) bad++;
    end
    pm = 4'b1000;
    for (int i = 6; i <= 12; i++) begin
      cyc(1);
      if (i == 6) begin
        n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL glitch_swi_down: got %b exp %b", swi, 1'b0); end
      end
      if (led !== LD || act !== 3'd3) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL glitch_output_held: got %0d bad cycles exp %0d", bad, 0); end
    n_chk++; if (sen !== 4'b1000) begin n_fail++; $display("FAIL glitch_sen: got %b exp %b", sen, 4'b1000); end
    $display("test_glitch_abort done");
  endtask

  task automatic test_retarget_in_wait;
    int bad;
    bad = 0;
    wait_phase(100);
    pm = 4'b0100;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (led !== LD) bad++;
    end
    n_chk++; if (swi !== 1'b1) begin n_fail++; $display("FAIL rt_wait_swi: got %b exp %b", swi, 1'b1); end
    n_chk++; if (act !== 3'd3) begin n_fail++; $display("FAIL rt_wait_act: got %0d exp %0d", act, 3); end
    pm = 4'b1010;
    for (int i = 21; i <= 102; i++) begin
      cyc(1);
      if (led !== LD) bad++;
    end
    n_chk++; if (act !== 3'd3) begin n_fail++; $display("FAIL rt_precommit_act: got %0d exp %0d", act, 3); end
    cyc(1);
    n_chk++; if (act !== 3'd1) begin n_fail++; $display("FAIL rt_commit_act: got %0d exp %0d", act, 1); end
    if (led !== LD) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rt_no_black_before_commit: got %0d bad cycles exp %0d", bad, 0); end
    cyc(1);
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL rt_blank_led: got %h exp %h", led, 16'h0000); end
    cyc(399);
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL rt_steady_swi: got %b exp %b", swi, 1'b0); end
    n_chk++; if (sen !== 4'b0010) begin n_fail++; $display("FAIL rt_steady_sen: got %b exp %b", sen, 4'b0010); end
    cyc(1);
    n_chk++; if (led !== LB) begin n_fail++; $display("FAIL rt_steady_led: got %h exp %h", led, LB); end
    n_chk++; if (oled !== OB) begin n_fail++; $display("FAIL rt_steady_oled: got %h exp %h", oled, OB); end
    $display("test_retarget_in_wait done");
  endtask

  task automatic test_priority_and_reset;
    wait_phase(150);
    pm = 4'b0101;
    cyc(52);
    n_chk++; if (act !== 3'd1) begin n_fail++; $display("FAIL pri_precommit_act: got %0d exp %0d", act, 1); end
    cyc(1);
    n_chk++; if (act !== 3'd0) begin n_fail++; $display("FAIL pri_commit_act: got %0d exp %0d", act, 0); end
    cyc(60);
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL pri_blank_led: got %h exp %h", led, 16'h0000); end
    n_chk++; if (swi !== 1'b1) begin n_fail++; $display("FAIL pri_blank_swi: got %b exp %b", swi, 1'b1); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL midrst_act: got %0d exp %0d", act, 4); end
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL midrst_swi: got %b exp %b", swi, 1'b0); end
    n_chk++; if (sen !== 4'b0000) begin n_fail++; $display("FAIL midrst_sen: got %b exp %b", sen, 4'b0000); end
    n_chk++; if (oled !== 16'h0000) begin n_fail++; $display("FAIL midrst_oled: got %h exp %h", oled, 16'h0000); end
    pm = 4'b0000;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    n_chk++; if (led !== SWV) begin n_fail++; $display("FAIL postrst_led: got %h exp %h", led, SWV); end
    n_chk++; if (oled !== OI) begin n_fail++; $display("FAIL postrst_oled: got %h exp %h", oled, OI); end
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL postrst_act: got %0d exp %0d", act, 4); end
    n_chk++; if (swi !== 1'b0) begin n_fail++; $display("FAIL postrst_swi: got %b exp %b", swi, 1'b0); end
    $display("test_priority_and_reset done");
  endtask

  task automatic test_zero_blank;
    wait_phase(194);
    pm = 4'b0001;
    cyc(12);
    n_chk++; if (act !== 3'd4) begin n_fail++; $display("FAIL zb_missed_tick_act: got %0d exp %0d", act, 4); end
    n_chk++; if (act0 !== 3'd4) begin n_fail++; $display("FAIL zb_missed_tick_act0: got %0d exp %0d", act0, 4); end
    n_chk++; if (swi0 !== 1'b1) begin n_fail++; $display("FAIL zb_wait_swi0: got %b exp %b", swi0, 1'b1); end
    cyc(196);
    n_chk++; if (act0 !== 3'd4) begin n_fail++; $display("FAIL zb_precommit_act0: got %0d exp %0d", act0, 4); end
    cyc(1);
    n_chk++; if (act0 !== 3'd0) begin n_fail++; $display("FAIL zb_commit_act0: got %0d exp %0d", act0, 0); end
    n_chk++; if (sen0 !== 4'b0001) begin n_fail++; $display("FAIL zb_commit_sen0: got %b exp %b", sen0, 4'b0001); end
    n_chk++; if (swi0 !== 1'b0) begin n_fail++; $display("FAIL zb_commit_swi0: got %b exp %b", swi0, 1'b0); end
    n_chk++; if (led0 !== SWV) begin n_fail++; $display("FAIL zb_commit_led0: got %h exp %h", led0, SWV); end
    n_chk++; if (act !== 3'd0) begin n_fail++; $display("FAIL zb_commit_act: got %0d exp %0d", act, 0); end
    cyc(1);
    n_chk++; if (led0 !== LA) begin n_fail++; $display("FAIL zb_steady_led0: got %h exp %h", led0, LA); end
    n_chk++; if (oled0 !== OA) begin n_fail++; $display("FAIL zb_steady_oled0: got %h exp %h", oled0, OA); end
    n_chk++; if (led !== 16'h0000) begin n_fail++; $display("FAIL zb_blank2_led: got %h exp %h", led, 16'h0000); end
    $display("test_zero_blank done");
  endtask

  initial begin
    test_reset();
    test_switch_to_d();
    test_glitch_abort();
    test_retarget_in_wait();
    test_priority_and_reset();
    test_zero_blank();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
